sequence_checker: RTL and testbench

//   Receive-side checker for a free-running modulo-2^WIDTH sequence counter stream.
//   - Samples count_in when valid_in is high and acquires lock on the incrementing sequence.
//   - Once locked, flags and counts every out-of-sequence sample and reports wrap-around.
//   - Sits downstream of the sequence counter, on any link carrying its count, as a link-integrity monitor.

---
 rtl/seq_pkg.sv | 14 +
 rtl/sat_counter.sv | 39 +++
 rtl/sequence_checker.sv | 146 ++++++++++++++
 tb/tb_sequence_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence counter / sequence checker pair.
//   SEQ_WIDTH : default sequence width, shared with the sequence counter
//   state_e   : checker FSM states (2-bit encoding)
package seq_pkg;

  localparam int unsigned SEQ_WIDTH = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : increment by one; holds once the count reaches all-ones
//   clr   : synchronous clear, takes priority over inc
//   count : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sequence_checker.sv
// Receive-side checker for a free-running modulo-2^WIDTH sequence stream.
// Acquires lock after LOCK_COUNT consecutive in-sequence samples, then flags
// and counts every out-of-sequence sample and drops lock after LOSS_COUNT
// consecutive mismatches.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   valid_in   : count_in is sampled this cycle
//   count_in   : received sequence value
//   err_clr    : synchronous clear of err_count (wins over a same-cycle error)
//   locked     : checker is in LOCKED
//   expected   : next value predicted for count_in
//   err_pulse  : one-cycle pulse, mismatch detected while LOCKED
//   wrap_pulse : one-cycle pulse, matching all-ones sample accepted while LOCKED
//   err_count  : saturating count of LOCKED mismatches
module sequence_checker
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH      = SEQ_WIDTH,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 err_clr,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  LOSS_LAST = BAD_W'(LOSS_COUNT);

  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic              err_pulse_q, err_pulse_d;
  logic              wrap_pulse_q, wrap_pulse_d;

  logic              match;
  logic              err_inc;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;

  assign match    = (count_in == exp_q);
  assign good_inc = good_q + 1'b1;
  assign bad_inc  = bad_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    bad_d        = bad_q;
    exp_d        = exp_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_inc      = 1'b0;

    if (valid_in) begin
      case (state_q)
        HUNT: begin
          exp_d   = count_in + 1'b1;
          good_d  = GOOD_ONE;
          state_d = SYNC;
        end

        SYNC: begin
          if (match) begin
            exp_d  = exp_q + 1'b1;
            good_d = good_inc;
            if (good_inc == LOCK_LAST) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            exp_d  = count_in + 1'b1;
            good_d = GOOD_ONE;
          end
        end

        LOCKED: begin
          // Expected always advances here: a corrupted sample must not
          // pull the prediction away from the free-running source.
          exp_d = exp_q + 1'b1;
          if (match) begin
            bad_d        = '0;
            wrap_pulse_d = (count_in == '1);
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            bad_d       = bad_inc;
            if (bad_inc == LOSS_LAST) begin
              state_d = HUNT;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      good_q       <= '0;
      bad_q        <= '0;
      exp_q        <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      exp_q        <= exp_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (err_clr),
    .count (err_count)
  );

  assign locked     = (state_q == LOCKED);
  assign expected   = exp_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker. Two instances share one stimulus
// stream: u_dut with an 8-bit error counter, u_dut_s with a 2-bit one.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [2:0] count_in;
  logic       err_clr;

  logic       locked,   locked_s;
  logic [2:0] expected, expected_s;
  logic       err_pulse, err_pulse_s;
  logic       wrap_pulse, wrap_pulse_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  always #5 clk = ~clk;

  sequence_checker #(
    .WIDTH      (3),
    .LOCK_COUNT (4),
    .LOSS_COUNT (2),
    .ERR_CNT_W  (8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .count_in   (count_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .expected   (expected),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count)
  );

  sequence_checker #(
    .WIDTH      (3),
    .LOCK_COUNT (4),
    .LOSS_COUNT (2),
    .ERR_CNT_W  (2)
  ) u_dut_s (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .count_in   (count_in),
    .err_clr    (err_clr),
    .locked     (locked_s),
    .expected   (expected_s),
    .err_pulse  (err_pulse_s),
    .wrap_pulse (wrap_pulse_s),
    .err_count  (err_count_s)
  );

  typedef struct {
    logic       lk;
    logic [2:0] ex;
    logic       ep;
    logic       wp;
    logic [7:0] e8;
    logic [1:0] e2;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int wrap_seen = 0;

  // reference model state: 0 = hunt, 1 = sync, 2 = locked
  int m_st, m_good, m_bad, m_exp, m_e8, m_e2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_good = 0; m_bad = 0; m_exp = 0; m_e8 = 0; m_e2 = 0;
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic clr);
    exp_t e;
    exp_t g;
    int   ci;
    ci   = int'(c);
    e.ep = 1'b0;
    e.wp = 1'b0;
    if (v) begin
      if (m_st == 0) begin
        m_exp = (ci + 1) % 8; m_good = 1; m_st = 1;
      end else if (m_st == 1) begin
        if (ci == m_exp) begin
          m_exp = (m_exp + 1) % 8;
          m_good++;
          if (m_good == 4) begin m_st = 2; m_bad = 0; end
        end else begin
          m_exp = (ci + 1) % 8; m_good = 1;
        end
      end else begin
        if (ci == m_exp) begin
          m_bad = 0;
          e.wp = (ci == 7);
        end else begin
          e.ep = 1'b1;
          if (m_e8 < 255) m_e8++;
          if (m_e2 < 3) m_e2++;
          m_bad++;
          if (m_bad == 2) m_st = 0;
        end
        m_exp = (m_exp + 1) % 8;
      end
    end
    if (clr) begin m_e8 = 0; m_e2 = 0; end
    e.lk = (m_st == 2);
    e.ex = 3'(m_exp);
    e.e8 = 8'(m_e8);
    e.e2 = 2'(m_e2);
    sb.push_back(e);

    valid_in = v;
    count_in = c;
    err_clr  = clr;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("locked",       32'(locked),       32'(g.lk));
      chk("expected",     32'(expected),     32'(g.ex));
      chk("err_pulse",    32'(err_pulse),    32'(g.ep));
      chk("wrap_pulse",   32'(wrap_pulse),   32'(g.wp));
      chk("err_count",    32'(err_count),    32'(g.e8));
      chk("locked_s",     32'(locked_s),     32'(g.lk));
      chk("expected_s",   32'(expected_s),   32'(g.ex));
      chk("err_count_s",  32'(err_count_s),  32'(g.e2));
    end
    if (err_pulse)  err_seen++;
    if (wrap_pulse) wrap_seen++;
    valid_in = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},  32'(locked),     32'd0);
    chk({tag, "_exp"},     32'(expected),   32'd0);
    chk({tag, "_errp"},    32'(err_pulse),  32'd0);
    chk({tag, "_wrapp"},   32'(wrap_pulse), 32'd0);
    chk({tag, "_errc"},    32'(err_count),  32'd0);
    chk({tag, "_errc_s"},  32'(err_count_s), 32'd0);
    chk({tag, "_lock_s"},  32'(locked_s),   32'd0);
  endtask

  initial begin
    logic [2:0] e;
    rst = 1'b1; valid_in = 1'b0; count_in = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: acquire lock on 0..3
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_exp", 32'(expected), 32'd4);
    chk("t1_errc", 32'(err_count), 32'd0);

    // 2: wrap through 7 -> 0, with an idle cycle in the middle
    wrap_seen = 0; err_seen = 0;
    step(1'b1, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    chk("t2_wraps", 32'(wrap_seen), 32'd1);
    chk("t2_errs", 32'(err_seen), 32'd0);
    chk("t2_locked", 32'(locked), 32'd1);

    // 3: single corrupted sample; expected flywheels over it
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    chk("t3_pre_exp", 32'(expected), 32'd5);
    err_seen = 0;
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    chk("t3_errs", 32'(err_seen), 32'd1);
    chk("t3_errc", 32'(err_count), 32'd1);
    chk("t3_locked", 32'(locked), 32'd1);
    chk("t3_exp", 32'(expected), 32'd0);

    // 4: two consecutive mismatches drop lock
    step(1'b0, 3'd0, 1'b1);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    chk("t4_pre_exp", 32'(expected), 32'd3);
    err_seen = 0;
    step(1'b1, 3'd6, 1'b0);
    chk("t4_still_locked", 32'(locked), 32'd1);
    step(1'b1, 3'd6, 1'b0);
    chk("t4_errs", 32'(err_seen), 32'd2);
    chk("t4_errc", 32'(err_count), 32'd2);
    chk("t4_unlocked", 32'(locked), 32'd0);

    // 5: resync inside SYNC, no errors reported
    err_seen = 0;
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd6, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    chk("t5_not_yet", 32'(locked), 32'd0);
    step(1'b1, 3'd0, 1'b0);
    chk("t5_locked", 32'(locked), 32'd1);
    chk("t5_errs", 32'(err_seen), 32'd0);

    // 6: saturation of the narrow counter
    step(1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      e = 3'(m_exp);
      step(1'b1, e ^ 3'd4, 1'b0);
      e = 3'(m_exp);
      step(1'b1, e, 1'b0);
    end
    chk("t6_sat", 32'(err_count_s), 32'd3);
    chk("t6_wide", 32'(err_count), 32'd5);
    chk("t6_locked", 32'(locked), 32'd1);
    e = 3'(m_exp);
    step(1'b1, e ^ 3'd4, 1'b1);
    chk("t6_clr", 32'(err_count_s), 32'd0);
    chk("t6_clr_w", 32'(err_count), 32'd0);
    chk("t6_clr_pulse", 32'(err_pulse), 32'd1);

    // asynchronous reset mid-lock, between clock edges
    e = 3'(m_exp);
    step(1'b1, e, 1'b0);
    chk("t6_prerst_locked", 32'(locked), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 3'd5, 1'b0);
    chk("post_rst_exp", 32'(expected), 32'd6);
    chk("post_rst_locked", 32'(locked), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
